mod_updown_counter: RTL and testbench
=====================================

MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 Parameter WIDTH, default 16, counter/data width (>=2).
REQ-002 Parameter STEP_W, default 4, step input width (<=WIDTH).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_  in  1  reset, synchronous, active-low.
REQ-005 ld_cnt  in  1  load request, active-low.
REQ-006 updn_cnt  in  1  direction: 1 up, 0 down.
REQ-007 count_enb  in  1  count enable, active-high.
REQ-008 step  in  STEP_W  unsigned increment/decrement amount.
REQ-009 max_val  in  WIDTH  runtime upper bound; legal range is 0..max_val.
REQ-010 data_in  in  WIDTH  load value.
REQ-011 clr_flags  in  1  clears sticky flags.
REQ-012 data_out  out  WIDTH  registered count.
REQ-013 tc  out  1  registered one-cycle pulse: the last update crossed a boundary.
REQ-014 ovf  out  1  sticky: an up-count crossed max_val.
REQ-015 unf  out  1  sticky: a down-count crossed 0.
REQ-016 at_max, at_zero  out  1 each  combinational: data_out==max_val and data_out==0.

Function
REQ-017 Priority per edge SHALL be: reset, then load (ld_cnt==0), then count (count_enb==1), else hold.
REQ-018 Load SHALL set data_out=min(data_in,max_val) and tc=0, with ovf/unf unchanged.
REQ-019 Effective step SHALL be eff=min(step,max_val+1), evaluated in WIDTH+1 bits.
REQ-020 Up count: s=data_out+eff (WIDTH+1 bits); if s<=max_val then data_out=s, else data_out=s-(max_val+1), tc=1, ovf=1.
REQ-021 Down count: if eff<=data_out then data_out=data_out-eff, else data_out=data_out+(max_val+1)-eff, tc=1, unf=1.
REQ-022 Count with data_out>max_val (max_val lowered at runtime) SHALL give data_out=0 (up, ovf=1) or max_val (down, unf=1), with tc=1.
REQ-023 step==0 SHALL leave data_out unchanged, with tc=0 and no flag change.
REQ-024 tc SHALL be 0 on every cycle without a boundary crossing, including hold and load cycles.
REQ-025 clr_flags SHALL clear ovf/unf; a flag set in the same cycle SHALL win over the clear.
REQ-026 max_val==0 SHALL keep data_out=0, and every enabled nonzero step SHALL pulse tc.
REQ-027 Latency SHALL be one cycle from input sample to data_out/tc/flags.

Reset
REQ-028 rst_==0 at a rising edge SHALL set data_out=0, tc=0, ovf=0, unf=0, overriding load and count.
REQ-029 Reset mid-count SHALL discard the pending update; counting resumes on the first edge with rst_==1.

Configuration
REQ-030 Macro MOD_UPDOWN_COUNTER_SAT_EN defined SHALL add input port sat_mode (1 bit); sat_mode==1 saturates crossings to max_val (up) or 0 (down), and tc/ovf/unf still assert.
REQ-031 Macro undefined SHALL omit sat_mode and always wrap per REQ-020..022.

Structure
REQ-032 Shared package mod_updown_counter_pkg SHALL hold the direction constants (CNT_UP=1, CNT_DN=0) and a typedef for the next-state result struct (value, crossed, is_up).
REQ-033 One sub-module mod_updown_next_val (combinational next-value/crossing computation) SHALL be used; the top holds only registers and priority.

Verification (WIDTH=8, STEP_W=4)
REQ-034 rst_=0 with ld_cnt=0, data_in=0x55 -> data_out=0, tc=0, ovf=unf=0.
REQ-035 max_val=9, load 7, up step=3 -> data_out=0 with tc=1 and ovf=1; next up step=3 -> 3 with tc=0.
REQ-036 max_val=9, data_out=1, down step=4 -> data_out=7 with tc=1 and unf=1; clr_flags=1 in the same cycle as a further underflow -> unf stays 1.
REQ-037 ld_cnt=0 and count_enb=1 together, data_in=0xF0, max_val=0x80 -> data_out=0x80, tc=0.
REQ-038 data_out=200, max_val changed to 100, count up step=1 -> data_out=0 with tc=1 and ovf=1.
REQ-039 With MOD_UPDOWN_COUNTER_SAT_EN and sat_mode=1, max_val=9, data_out=8, up step=5 -> data_out=9 with tc=1 and ovf=1.

Source files
------------

// File: rtl/mod_updown_counter_pkg.sv
// Shared constants and the next-value result type for mod_updown_counter.
// The result value field is sized for the widest supported counter (NV_MAX_W).
package mod_updown_counter_pkg;
  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DN   = 1'b0;
  localparam int   NV_MAX_W = 64;

  typedef struct packed {
    logic [NV_MAX_W-1:0] value;
    logic                crossed;
    logic                is_up;
  } nv_t;
endpackage

// File: rtl/mod_updown_next_val.sv
// Combinational next-count / boundary-crossing computation for mod_updown_counter.
// With MOD_UPDOWN_COUNTER_SAT_EN defined, a sat_mode input clamps crossings.
module mod_updown_next_val
  import mod_updown_counter_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STEP_W = 4
) (
  input  logic [WIDTH-1:0]  cur,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  max_val,
  input  logic              updn,
`ifdef MOD_UPDOWN_COUNTER_SAT_EN
  input  logic              sat_mode,
`endif
  output nv_t               res
);
  localparam int XW = WIDTH + 1;

  logic          sat;
  logic [XW-1:0] mx, m1, stx, eff, cx, s, v;
  logic          crossed;

`ifdef MOD_UPDOWN_COUNTER_SAT_EN
  assign sat = sat_mode;
`else
  assign sat = 1'b0;
`endif

  always_comb begin
    mx      = {1'b0, max_val};
    m1      = mx + XW'(1);
    stx     = XW'(step);
    eff     = (stx < m1) ? stx : m1;
    cx      = {1'b0, cur};
    s       = cx + eff;
    v       = cx;
    crossed = 1'b0;
    // A zero step is a no-op even when the count sits above a lowered max_val.
    if (step != '0) begin
      if (cx > mx) begin
        crossed = 1'b1;
        if (updn == CNT_UP) v = sat ? mx : '0;
        else                v = sat ? '0 : mx;
      end else if (updn == CNT_UP) begin
        if (s <= mx) v = s;
        else begin
          crossed = 1'b1;
          v       = sat ? mx : s - m1;
        end
      end else begin
        if (eff <= cx) v = cx - eff;
        else begin
          crossed = 1'b1;
          v       = sat ? '0 : cx + m1 - eff;
        end
      end
    end
  end

  assign res.value   = {{(NV_MAX_W-WIDTH){1'b0}}, v[WIDTH-1:0]};
  assign res.crossed = crossed;
  assign res.is_up   = updn;
endmodule

// File: rtl/mod_updown_counter.sv
// Bounded up/down counter with load, wrap (or saturate), tc pulse and sticky flags.
// Optional MOD_UPDOWN_COUNTER_SAT_EN adds the sat_mode input.
module mod_updown_counter
  import mod_updown_counter_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              ld_cnt,
  input  logic              updn_cnt,
  input  logic              count_enb,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  max_val,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              clr_flags,
`ifdef MOD_UPDOWN_COUNTER_SAT_EN
  input  logic              sat_mode,
`endif
  output logic [WIDTH-1:0]  data_out,
  output logic              tc,
  output logic              ovf,
  output logic              unf,
  output logic              at_max,
  output logic              at_zero
);
  nv_t              nv;
  logic [WIDTH-1:0] ld_val;
  logic             do_cnt;

  mod_updown_next_val #(.WIDTH(WIDTH), .STEP_W(STEP_W)) u_next (
    .cur      (data_out),
    .step     (step),
    .max_val  (max_val),
    .updn     (updn_cnt),
`ifdef MOD_UPDOWN_COUNTER_SAT_EN
    .sat_mode (sat_mode),
`endif
    .res      (nv)
  );

  assign ld_val = (data_in > max_val) ? max_val : data_in;
  assign do_cnt = ld_cnt && count_enb;

  always_ff @(posedge clk) begin
    if (!rst_) begin
      data_out <= '0;
      tc       <= 1'b0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
    end else begin
      if (!ld_cnt)     data_out <= ld_val;
      else if (do_cnt) data_out <= nv.value[WIDTH-1:0];
      tc <= do_cnt && nv.crossed;
      // Setting a flag takes precedence over clearing it in the same cycle.
      ovf <= (ovf && !clr_flags) || (do_cnt && nv.crossed &&  nv.is_up);
      unf <= (unf && !clr_flags) || (do_cnt && nv.crossed && !nv.is_up);
    end
  end

  assign at_max  = (data_out == max_val);
  assign at_zero = (data_out == '0);
endmodule

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench for mod_updown_counter (WIDTH=8, STEP_W=4): directed
// boundary scenarios plus randomized traffic against an arithmetic model.
module tb_mod_updown_counter;
  localparam int WIDTH  = 8;
  localparam int STEP_W = 4;

  logic              clk = 1'b0;
  logic              rst_ = 1'b0;
  logic              ld_cnt = 1'b1;
  logic              updn_cnt = 1'b1;
  logic              count_enb = 1'b0;
  logic [STEP_W-1:0] step = '0;
  logic [WIDTH-1:0]  max_val = 8'hFF;
  logic [WIDTH-1:0]  data_in = '0;
  logic              clr_flags = 1'b0;
  logic              sat_mode = 1'b0;
  logic [WIDTH-1:0]  data_out;
  logic              tc, ovf, unf, at_max, at_zero;

  int total = 0;
  int bad   = 0;

  int m_cnt = 0;
  bit m_tc = 0, m_ovf = 0, m_unf = 0;

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .ld_cnt    (ld_cnt),
    .updn_cnt  (updn_cnt),
    .count_enb (count_enb),
    .step      (step),
    .max_val   (max_val),
    .data_in   (data_in),
    .clr_flags (clr_flags),
`ifdef MOD_UPDOWN_COUNTER_SAT_EN
    .sat_mode  (sat_mode),
`endif
    .data_out  (data_out),
    .tc        (tc),
    .ovf       (ovf),
    .unf       (unf),
    .at_max    (at_max),
    .at_zero   (at_zero)
  );

  // Reference model: modular arithmetic on plain ints, from the counter rules.
  task automatic model_update();
    int mx, e, s, st;
    mx   = int'(max_val);
    st   = int'(step);
    m_tc = 0;
    if (!rst_) begin
      m_cnt = 0; m_ovf = 0; m_unf = 0;
    end else begin
      if (clr_flags) begin m_ovf = 0; m_unf = 0; end
      if (!ld_cnt) m_cnt = (int'(data_in) > mx) ? mx : int'(data_in);
      else if (count_enb && st != 0) begin
        e = (st < mx + 1) ? st : mx + 1;
        if (m_cnt > mx) begin
          m_tc = 1;
          if (updn_cnt) begin m_cnt = sat_mode ? mx : 0; m_ovf = 1; end
          else          begin m_cnt = sat_mode ? 0 : mx; m_unf = 1; end
        end else if (updn_cnt) begin
          s = m_cnt + e;
          if (s > mx) begin m_cnt = sat_mode ? mx : s - (mx + 1); m_tc = 1; m_ovf = 1; end
          else m_cnt = s;
        end else begin
          if (e <= m_cnt) m_cnt = m_cnt - e;
          else begin m_cnt = sat_mode ? 0 : m_cnt + (mx + 1) - e; m_tc = 1; m_unf = 1; end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    rst_ = 1; ld_cnt = 1; count_enb = 0; clr_flags = 0; step = '0;
  endtask

  task automatic load(input int mx, input int v);
    idle(); max_val = WIDTH'(mx); data_in = WIDTH'(v); ld_cnt = 0;
    tick();
    ld_cnt = 1;
  endtask

  task automatic do_reset();
    idle(); rst_ = 0; tick(); rst_ = 1;
  endtask

  task automatic test_reset();
    rst_ = 0; ld_cnt = 0; count_enb = 1; data_in = 8'h55; step = 4'd3;
    tick();
    total++;
    if ({data_out, tc, ovf, unf} !== {8'h00, 3'b000}) begin
      bad++; $display("FAIL reset: got out=%0h tc=%0b ovf=%0b unf=%0b, need 0 0 0 0", data_out, tc, ovf, unf);
    end
    total++;
    if (at_zero !== 1'b1) begin bad++; $display("FAIL reset_at_zero: got %0b need 1", at_zero); end
    idle();
  endtask

  task automatic test_up_wrap();
    do_reset(); load(9, 7);
    count_enb = 1; updn_cnt = 1; step = 4'd3;
    tick();
    total++;
    if ({data_out, tc, ovf, unf} !== {8'd0, 3'b110}) begin
      bad++; $display("FAIL up_wrap: got out=%0d tc=%0b ovf=%0b unf=%0b, need 0 1 1 0", data_out, tc, ovf, unf);
    end
    tick();
    total++;
    if ({data_out, tc, ovf} !== {8'd3, 2'b01}) begin
      bad++; $display("FAIL up_after_wrap: got out=%0d tc=%0b ovf=%0b, need 3 0 1", data_out, tc, ovf);
    end
    idle();
  endtask

  task automatic test_down_wrap();
    do_reset(); load(9, 1);
    count_enb = 1; updn_cnt = 0; step = 4'd4;
    tick();
    total++;
    if ({data_out, tc, ovf, unf} !== {8'd7, 3'b101}) begin
      bad++; $display("FAIL down_wrap: got out=%0d tc=%0b ovf=%0b unf=%0b, need 7 1 0 1", data_out, tc, ovf, unf);
    end
    step = 4'd8; clr_flags = 1;
    tick();
    total++;
    if ({data_out, tc, unf} !== {8'd9, 2'b11}) begin
      bad++; $display("FAIL set_beats_clr: got out=%0d tc=%0b unf=%0b, need 9 1 1", data_out, tc, unf);
    end
    count_enb = 0;
    tick();
    total++;
    if ({data_out, tc, unf, at_max} !== {8'd9, 3'b001}) begin
      bad++; $display("FAIL clr_flags: got out=%0d tc=%0b unf=%0b at_max=%0b, need 9 0 0 1", data_out, tc, unf, at_max);
    end
    idle();
  endtask

  task automatic test_load_priority();
    do_reset();
    max_val = 8'h80; data_in = 8'hF0; ld_cnt = 0; count_enb = 1; updn_cnt = 1; step = 4'd5;
    tick();
    total++;
    if ({data_out, tc, at_max} !== {8'h80, 2'b01}) begin
      bad++; $display("FAIL load_priority: got out=%0h tc=%0b at_max=%0b, need 80 0 1", data_out, tc, at_max);
    end
    idle();
  endtask

  task automatic test_range_shrink();
    do_reset(); load(255, 200);
    max_val = 8'd100; count_enb = 1; updn_cnt = 1; step = 4'd1;
    tick();
    total++;
    if ({data_out, tc, ovf} !== {8'd0, 2'b11}) begin
      bad++; $display("FAIL shrink_up: got out=%0d tc=%0b ovf=%0b, need 0 1 1", data_out, tc, ovf);
    end
    load(255, 200);
    max_val = 8'd100; count_enb = 1; updn_cnt = 0; step = 4'd1;
    tick();
    total++;
    if ({data_out, tc, unf} !== {8'd100, 2'b11}) begin
      bad++; $display("FAIL shrink_dn: got out=%0d tc=%0b unf=%0b, need 100 1 1", data_out, tc, unf);
    end
    idle();
  endtask

  task automatic test_max_zero();
    do_reset(); load(0, 33);
    count_enb = 1;
    for (int i = 0; i < 4; i++) begin
      updn_cnt = i[0]; step = (i == 3) ? 4'd0 : 4'(5 + i);
      tick();
      total++;
      if ({data_out, tc, at_zero, at_max} !== {8'd0, (i != 3), 2'b11}) begin
        bad++; $display("FAIL max_zero[%0d]: got out=%0d tc=%0b, need 0 %0b", i, data_out, tc, (i != 3));
      end
    end
    idle();
  endtask

  task automatic test_reset_midcount();
    do_reset(); load(50, 20);
    count_enb = 1; updn_cnt = 1; step = 4'd7; rst_ = 0;
    tick();
    total++;
    if (data_out !== 8'd0) begin bad++; $display("FAIL reset_midcount: got %0d need 0", data_out); end
    rst_ = 1;
    tick();
    total++;
    if ({data_out, tc} !== {8'd7, 1'b0}) begin
      bad++; $display("FAIL resume_after_reset: got out=%0d tc=%0b, need 7 0", data_out, tc);
    end
    idle();
  endtask

`ifdef MOD_UPDOWN_COUNTER_SAT_EN
  task automatic test_saturate();
    do_reset(); load(9, 8);
    sat_mode = 1; count_enb = 1; updn_cnt = 1; step = 4'd5;
    tick();
    total++;
    if ({data_out, tc, ovf} !== {8'd9, 2'b11}) begin
      bad++; $display("FAIL saturate: got out=%0d tc=%0b ovf=%0b, need 9 1 1", data_out, tc, ovf);
    end
    sat_mode = 0;
    idle();
  endtask
`endif

  task automatic test_random();
    int mx_pool[4] = '{0, 9, 100, 255};
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst_      = ($urandom_range(0, 39) != 0);
      ld_cnt    = ($urandom_range(0, 7) != 0);
      count_enb = ($urandom_range(0, 3) != 0);
      updn_cnt  = $urandom_range(0, 1);
      step      = STEP_W'($urandom);
      data_in   = WIDTH'($urandom);
      clr_flags = ld_cnt && ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 9) == 0)
        max_val = ($urandom_range(0, 1) != 0) ? WIDTH'(mx_pool[$urandom_range(0, 3)]) : WIDTH'($urandom);
      tick();
      total++;
      if ({data_out, tc, ovf, unf} !== {WIDTH'(m_cnt), m_tc, m_ovf, m_unf}) begin
        bad++;
        $display("FAIL random[%0d]: got out=%0d tc=%0b ovf=%0b unf=%0b, need %0d %0b %0b %0b",
                 n, data_out, tc, ovf, unf, m_cnt, m_tc, m_ovf, m_unf);
      end
      total++;
      if ({at_max, at_zero} !== {(m_cnt == int'(max_val)), (m_cnt == 0)}) begin
        bad++;
        $display("FAIL random_cmp[%0d]: got at_max=%0b at_zero=%0b, need %0b %0b",
                 n, at_max, at_zero, (m_cnt == int'(max_val)), (m_cnt == 0));
      end
    end
    idle();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load_priority();
    test_range_shrink();
    test_max_zero();
    test_reset_midcount();
`ifdef MOD_UPDOWN_COUNTER_SAT_EN
    test_saturate();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
